// File: rtl/grid_avalon_slave_if.sv
// rtl/grid_avalon_slave_if.sv - Avalon-MM read-only bus bundle for grid_avalon_slave
interface grid_avalon_slave_if;
  logic        avs_read;
  logic [4:0]  avs_address;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport slave (
    input  avs_read,
    input  avs_address,
    output avs_readdata,
    output avs_readdatavalid
  );

  modport master (
    output avs_read,
    output avs_address,
    input  avs_readdata,
    input  avs_readdatavalid
  );
endinterface

// File: rtl/grid_avalon_slave.sv
// rtl/grid_avalon_slave.sv - Avalon-MM status/grid register slave, fixed read latency 1
// Optional macro GRID_SNAPSHOT_EN: STATUS reads snapshot grid_state/score for SCORE/GRID reads.
module grid_avalon_slave #(
  parameter logic [31:0] ID_VALUE = 32'h5445_5452
) (
  input  logic                 clk,
  input  logic                 reset,
  grid_avalon_slave_if.slave   avs,
  input  logic [199:0]         grid_state,
  input  logic [13:0]          score,
  input  logic                 row_cleared,
  input  logic                 game_over,
  output logic                 irq
);

  logic [199:0] prev_grid_q;
  logic         prev_row_q, prev_over_q;
  logic         row_evt_q, row_evt_d;
  logic         grid_evt_q, grid_evt_d;
  logic         over_evt_q, over_evt_d;
  logic [15:0]  frame_count_q, frame_count_d;
  logic [31:0]  readdata_q, readdata_d;
  logic         valid_q;
  logic         irq_q;
  logic         row_set, over_set, grid_set, status_rd;
  logic [199:0] rd_grid;
  logic [13:0]  rd_score;

`ifdef GRID_SNAPSHOT_EN
  logic [199:0] shadow_grid_q;
  logic [13:0]  shadow_score_q;
  assign rd_grid  = shadow_grid_q;
  assign rd_score = shadow_score_q;
`else
  assign rd_grid  = grid_state;
  assign rd_score = score;
`endif

  assign row_set   = row_cleared & ~prev_row_q;
  assign over_set  = game_over & ~prev_over_q;
  assign grid_set  = (grid_state != prev_grid_q);
  assign status_rd = avs.avs_read && (avs.avs_address == 5'd0);

  // Set wins over the clear from a coincident STATUS read.
  always_comb begin
    row_evt_d     = row_set  | (row_evt_q  & ~status_rd);
    grid_evt_d    = grid_set | (grid_evt_q & ~status_rd);
    over_evt_d    = over_set | (over_evt_q & ~status_rd);
    frame_count_d = frame_count_q + {15'd0, grid_set};
  end

  always_comb begin
    readdata_d = readdata_q;
    if (avs.avs_read) begin
      case (avs.avs_address)
        5'h00:   readdata_d = {frame_count_q, 12'd0, over_evt_q, grid_evt_q, row_evt_q, game_over};
        5'h01:   readdata_d = {18'd0, rd_score};
        5'h02:   readdata_d = rd_grid[31:0];
        5'h03:   readdata_d = rd_grid[63:32];
        5'h04:   readdata_d = rd_grid[95:64];
        5'h05:   readdata_d = rd_grid[127:96];
        5'h06:   readdata_d = rd_grid[159:128];
        5'h07:   readdata_d = rd_grid[191:160];
        5'h08:   readdata_d = {24'd0, rd_grid[199:192]};
        5'h09:   readdata_d = ID_VALUE;
        default: readdata_d = 32'd0;
      endcase
    end
  end

  // Edge detectors are primed from live inputs during reset so release raises nothing.
  always_ff @(posedge clk) begin
    prev_grid_q <= grid_state;
    prev_row_q  <= row_cleared;
    prev_over_q <= game_over;
    if (reset) begin
      row_evt_q     <= 1'b0;
      grid_evt_q    <= 1'b0;
      over_evt_q    <= 1'b0;
      frame_count_q <= 16'd0;
      readdata_q    <= 32'd0;
      valid_q       <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      row_evt_q     <= row_evt_d;
      grid_evt_q    <= grid_evt_d;
      over_evt_q    <= over_evt_d;
      frame_count_q <= frame_count_d;
      readdata_q    <= readdata_d;
      valid_q       <= avs.avs_read;
      irq_q         <= row_evt_d | over_evt_d;
    end
  end

`ifdef GRID_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_grid_q  <= 200'd0;
      shadow_score_q <= 14'd0;
    end else if (status_rd) begin
      shadow_grid_q  <= grid_state;
      shadow_score_q <= score;
    end
  end
`endif

  assign avs.avs_readdata      = readdata_q;
  assign avs.avs_readdatavalid = valid_q;
  assign irq                   = irq_q;

endmodule
